// File: rtl/nn_pkg.sv
// Shared constants and FSM state encoding for the dense-layer MAC sequencer.
package nn_pkg;

  localparam int WIDTH         = 8;
  localparam int ACT_W         = 2 * WIDTH;
  localparam int ACC_W         = 4 * WIDTH;
  localparam int RESCALE_SHIFT = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/relu_requant.sv
// ReLU followed by an arithmetic right shift and positive saturation to the
// activation width.
module relu_requant #(
  parameter int ACC_W = nn_pkg::ACC_W,
  parameter int ACT_W = nn_pkg::ACT_W
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [ACT_W-1:0] o_act
);

  import nn_pkg::RESCALE_SHIFT;

  logic signed [ACC_W-1:0] w_shift;
  logic signed [ACC_W-1:0] w_max;

  assign w_shift = i_acc >>> RESCALE_SHIFT;
  assign w_max   = {{(ACC_W-ACT_W+1){1'b0}}, {(ACT_W-1){1'b1}}};

  always_comb begin
    o_act = '0;
    if (i_acc[ACC_W-1] || (i_acc == '0)) begin
      o_act = '0;
    end else if (w_shift > w_max) begin
      o_act = {1'b0, {(ACT_W-1){1'b1}}};
    end else begin
      o_act = w_shift[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/dense_mac_sequencer.sv
// Dense layer evaluated on one shared MAC: walks (neuron, input) pairs against
// synchronous RAM/ROMs, accumulates, then writes one ReLU'd result per neuron.
module dense_mac_sequencer #(
  parameter int NEURON_NB = 32,
  parameter int IN_SIZE   = 196,
  parameter int WIDTH     = nn_pkg::WIDTH,
  localparam int IN_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
  localparam int WA_W = (NEURON_NB*IN_SIZE > 1) ? $clog2(NEURON_NB*IN_SIZE) : 1,
  localparam int NB_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [IN_W-1:0]           in_addr,
  input  logic signed [2*WIDTH-1:0] in_data,
  output logic [WA_W-1:0]           w_addr,
  input  logic signed [WIDTH-1:0]   w_data,
  output logic [NB_W-1:0]           b_addr,
  input  logic signed [WIDTH-1:0]   b_data,
  output logic                      out_we,
  output logic [NB_W-1:0]           out_addr,
  output logic signed [2*WIDTH-1:0] out_data
);

  import nn_pkg::*;

  localparam int AW = 2 * WIDTH;
  localparam int CW = 4 * WIDTH;

  state_t                   r_state;
  logic [IN_W-1:0]          r_k;
  logic [NB_W-1:0]          r_n;
  logic [WA_W-1:0]          r_waddr;
  logic                     r_vld;
  logic                     r_first;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_we;
  logic signed [CW-1:0]     r_acc;

  logic signed [3*WIDTH-1:0] w_prod;
  logic signed [CW-1:0]      w_prod_x;
  logic signed [CW-1:0]      w_bias_x;
  logic signed [AW-1:0]      w_relu;

  assign w_prod   = in_data * w_data;
  assign w_prod_x = {{WIDTH{w_prod[3*WIDTH-1]}}, w_prod};
  assign w_bias_x = {{(3*WIDTH){b_data[WIDTH-1]}}, b_data};

  // Weight address is a running counter (n*IN_SIZE+k) rather than a multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_n     <= '0;
      r_waddr <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_vld   <= (r_state == FETCH);
      r_first <= (r_state == FETCH) && (r_k == '0);
      if (r_vld) begin
        r_acc <= r_first ? (w_bias_x + w_prod_x) : (r_acc + w_prod_x);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_k     <= '0;
            r_n     <= '0;
            r_waddr <= '0;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_waddr <= r_waddr + 1'b1;
          if (r_k == IN_W'(IN_SIZE-1)) begin
            r_k     <= '0;
            r_state <= DRAIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRAIN: begin
          r_state <= WRITE;
          r_we    <= 1'b1;
        end
        WRITE: begin
          if (r_n == NB_W'(NEURON_NB-1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_n     <= r_n + 1'b1;
            r_k     <= '0;
            r_state <= FETCH;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  relu_requant #(
    .ACC_W(CW),
    .ACT_W(AW)
  ) u_relu (
    .i_acc(r_acc),
    .o_act(w_relu)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign out_we   = r_we;
  assign out_addr = r_n;
  assign out_data = w_relu;
  assign in_addr  = r_k;
  assign w_addr   = r_waddr;
  assign b_addr   = r_n;

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// Scoreboard bench for dense_mac_sequencer with 2 neurons x 3 inputs and
// 1-cycle-latency memory models.
module tb_dense_mac_sequencer;

  localparam int NB = 2;
  localparam int IS = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy, done, out_we;
  logic [1:0]         in_addr;
  logic [2:0]         w_addr;
  logic [0:0]         b_addr, out_addr;
  logic signed [15:0] in_data, out_data;
  logic signed [7:0]  w_data, b_data;

  logic signed [15:0] act  [IS];
  logic signed [7:0]  wgt  [NB*IS];
  logic signed [7:0]  bias [NB];

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int start_cyc = 0;
  int we_total = 0;
  int done_total = 0;
  logic [2:0] w_log    [32];
  logic [1:0] in_log   [32];
  logic       busy_log [32];
  logic       done_log [32];
  logic       we_log   [32];

  int                 exp_addr [$];
  logic signed [15:0] exp_data [$];

  always #5 clk = ~clk;

  dense_mac_sequencer #(
    .NEURON_NB(NB),
    .IN_SIZE  (IS),
    .WIDTH    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .in_addr (in_addr),
    .in_data (in_data),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .out_we  (out_we),
    .out_addr(out_addr),
    .out_data(out_data)
  );

  always @(posedge clk) begin
    in_data <= act[in_addr < 2'd3 ? in_addr : 2'd0];
    w_data  <= (w_addr < 3'd6) ? wgt[w_addr] : 8'sd0;
    b_data  <= bias[b_addr];
    cyc     <= cyc + 1;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    int idx;
    idx = cyc - start_cyc;
    if (idx >= 0 && idx < 32) begin
      w_log[idx]    = w_addr;
      in_log[idx]   = in_addr;
      busy_log[idx] = busy;
      done_log[idx] = done;
      we_log[idx]   = out_we;
    end
    if (done === 1'b1) done_total++;
    if (out_we === 1'b1) begin
      we_total++;
      if (exp_addr.size() == 0) begin
        check("unexpected_out_we", 1, 0);
      end else begin
        check("out_addr", out_addr, exp_addr.pop_front());
        check("out_data", out_data, exp_data.pop_front());
      end
    end
  end

  function automatic logic signed [15:0] model(input int n);
    longint s;
    logic signed [31:0] s32;
    logic signed [31:0] t;
    s = longint'(bias[n]);
    for (int k = 0; k < IS; k++) s += longint'(act[k]) * longint'(wgt[n*IS+k]);
    s32 = s[31:0];
    if (s32 <= 0) return 16'sd0;
    t = s32 >>> 8;
    if (t > 32767) return 16'sd32767;
    return t[15:0];
  endfunction

  task automatic push_expected(input int nmax);
    for (int n = 0; n < nmax; n++) begin
      exp_addr.push_back(n);
      exp_data.push_back(model(n));
    end
  endtask

  task automatic set_mem(input logic signed [15:0] a0, a1, a2,
                         input logic signed [7:0] w0, w1, w2, w3, w4, w5,
                         input logic signed [7:0] b0, b1);
    act[0] = a0; act[1] = a1; act[2] = a2;
    wgt[0] = w0; wgt[1] = w1; wgt[2] = w2;
    wgt[3] = w3; wgt[4] = w4; wgt[5] = w5;
    bias[0] = b0; bias[1] = b1;
  endtask

  task automatic kick(input bit hold);
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic run_layer(input int nruns, input bit hold);
    int we0, dn0;
    for (int r = 0; r < nruns; r++) push_expected(NB);
    we0 = we_total;
    dn0 = done_total;
    kick(hold);
    for (int i = 0; i < 20*nruns && (done_total - dn0) < nruns; i++) begin
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    check("done_seen", done_total - dn0, nruns);
    repeat (2) @(negedge clk);
    #1;
    check("we_count", we_total - we0, NB*nruns);
    check("sb_empty", exp_addr.size(), 0);
  endtask

  task automatic check_timing(input int nruns);
    for (int r = 0; r < nruns; r++) begin
      int base;
      base = r * (NB*(IS+2) + 2);
      check("done_latency", done_log[base+NB*(IS+2)+1], 1);
      check("done_not_early", done_log[base+NB*(IS+2)], 0);
      check("busy_idle_after", busy_log[base+NB*(IS+2)+2], 0);
      for (int i = 1; i <= NB*(IS+2)+1; i++) check("busy_high", busy_log[base+i], 1);
      for (int n = 0; n < NB; n++) begin
        check("we_pulse", we_log[base+(n+1)*(IS+2)], 1);
        for (int k = 0; k < IS; k++) begin
          check("w_addr_seq", w_log[base+n*(IS+2)+k+1], n*IS+k);
          check("in_addr_seq", in_log[base+n*(IS+2)+k+1], k);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, dn0;
    reset = 1'b1;
    start = 1'b0;
    set_mem(16'sd256, 16'sd512, -16'sd256, 8'sd1, 8'sd2, 8'sd3,
            -8'sd1, -8'sd1, -8'sd1, 8'sd0, 8'sd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_we", out_we, 0);
    check("rst_in_addr", in_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_b_addr", b_addr, 0);
    reset = 1'b0;

    // basic layer: (0,2) then (1,0), plus latency and address sweep
    check("model_basic0", model(0), 2);
    check("model_basic1", model(1), 0);
    run_layer(1, 1'b0);
    check_timing(1);

    // saturation
    set_mem(16'sd32767, 16'sd32767, 16'sd32767, 8'sd127, 8'sd127, 8'sd127,
            -8'sd1, -8'sd1, -8'sd1, 8'sd0, 8'sd5);
    check("model_sat", model(0), 32767);
    run_layer(1, 1'b0);

    // bias only, then small positive bias plus one product
    set_mem(16'sd0, 16'sd0, 16'sd0, 8'sd5, 8'sd6, 8'sd7,
            8'sd9, 8'sd9, 8'sd9, -8'sd1, 8'sd100);
    run_layer(1, 1'b0);
    set_mem(16'sd256, 16'sd0, 16'sd0, 8'sd0, 8'sd0, 8'sd0,
            8'sd1, 8'sd0, 8'sd0, -8'sd1, 8'sd127);
    check("model_bias1", model(1), 1);
    run_layer(1, 1'b0);

    // reset during the second neuron's fetch
    set_mem(16'sd256, 16'sd512, -16'sd256, 8'sd1, 8'sd2, 8'sd3,
            -8'sd1, -8'sd1, -8'sd1, 8'sd0, 8'sd5);
    push_expected(1);
    we0 = we_total;
    dn0 = done_total;
    kick(1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_we", out_we, 0);
    check("abort_done", done, 0);
    check("abort_w_addr", w_addr, 0);
    check("abort_in_addr", in_addr, 0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("abort_we_count", we_total - we0, 1);
    check("abort_done_count", done_total - dn0, 0);
    check("abort_sb_empty", exp_addr.size(), 0);
    run_layer(1, 1'b0);
    check_timing(1);

    // start held high: back-to-back runs with one idle cycle between
    run_layer(2, 1'b1);
    check_timing(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
